id_stage: RTL
=============

# id_stage

Instruction-decode stage of the 5-stage pipeline, directly downstream of the instruction-fetch stage. Contains the IF/ID pipeline register, the 32x32 register file, the decoder, branch resolution and the ID/EX pipeline register. Branch resolution drives `branch_taken`/`branch_address` back to the fetch stage. Operands and control go forward to the execute stage.

## Interface
- Parameters: none. Data is 32-bit, register index is 5-bit, 32 registers.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-low.
- `if_instruction` in 32: instruction fetched this cycle.
- `if_pc` in 32: byte address of `if_instruction`.
- `wb_wb_en` in 1: register-file write enable from write-back.
- `wb_dest` in 5: write-back destination register.
- `wb_value` in 32: write-back data.
- `branch_taken` out 1: combinational; redirect fetch.
- `branch_address` out 32: combinational; byte target for fetch.
- `ex_pc` out 32: registered; branch/instruction PC + 4.
- `ex_val1` out 32: registered; operand 1.
- `ex_val2` out 32: registered; operand 2.
- `ex_st_val` out 32: registered; store data.
- `ex_dest` out 5: registered; destination register.
- `ex_exe_cmd` out 4: registered; ALU command.
- `ex_mem_read` out 1: registered; load control.
- `ex_mem_write` out 1: registered; store control.
- `ex_wb_en` out 1: registered; write-back enable.

## Operation

**Field layout**
- op=[31:26], rs1=[25:21], rs2=[20:16], rd_r=[15:11], imm=[15:0].
- imm is always sign-extended to 32 bits.

**Opcodes and decode** (opcode: effect, exe_cmd)
- R-type, writes rd_r, val2=R[rs2]:
  - 1 ADD: 0000
  - 3 SUB: 0010
  - 5 AND: 0100
  - 6 OR: 0101
  - 7 NOR: 0110
  - 8 XOR: 0111
  - 9 SLA: 1000
  - 10 SLL: 1000
  - 11 SRA: 1001
  - 12 SRL: 1010
- I-type, dest=rs2, val2=sext(imm):
  - 32 ADDI: 0000
  - 33 SUBI: 0010
- 36 LD: dest=rs2, val2=sext(imm), cmd 0000, mem_read=1, wb_en=1.
- 37 ST: val1=R[rs1], val2=sext(imm), st_val=R[rs2], cmd 0000, mem_write=1, wb_en=0.
- Branches (no write-back, no memory access; ID/EX gets a bubble):
  - 40 BEZ: taken if R[rs1]==0.
  - 41 BNE: taken if R[rs1]!=R[rs2].
  - 42 JMP: always taken.
- Opcode 0 and any unlisted opcode are NOPs: all control outputs 0.

**Register file**
- R0 always reads 0; writes to R0 are ignored.
- Writes occur on the rising edge when `wb_wb_en`=1.
- Reads are combinational with write-through bypass: if `wb_wb_en` and `wb_dest`==read index!=0, the read returns `wb_value`.

**Branch resolution**
- Computed from the IF/ID instruction.
- `branch_address` = IF/ID pc + 4 + (sext(imm) << 2), mod 2^32.
- `branch_taken` is forced 0 while `rst`=0.

**Flush**
- When `branch_taken`=1, the IF/ID register loads instruction 0 (NOP) at the next edge instead of `if_instruction`. This kills one wrong-path instruction.

**Hazards**
- No interlock or forwarding; software inserts NOPs. The only forwarding is the write-through bypass.

## Timing
- Reset (asynchronous, `rst`=0) clears:
  - IF/ID instruction and pc.
  - All 32 registers.
  - All `ex_*` outputs to 0.
  - Combinational outputs during reset: `branch_taken`=0, `branch_address` is a don't-care.
- Reset asserted mid-operation takes effect immediately, without a clock edge.
- Latency:
  - Instruction at `if_instruction` in cycle n is decoded in cycle n+1.
  - Its operands appear on `ex_*` in cycle n+2.
  - `branch_taken` is valid in cycle n+1, so fetch's PC equals the target in cycle n+2.
- Simultaneous write-back and read of the same register: the new value is used (bypass).
- Back-to-back taken branches: each taken branch flushes the following slot, so a self-loop (JMP -1) produces alternating branch/NOP in IF/ID. `branch_taken` asserts every other cycle. The ID/EX register receives only bubbles.

## Test plan
1. **Reset mid-run:** pulse `rst`=0 between edges.
   - All `ex_*` go to 0 immediately; `branch_taken`=0.
   - After release, ADD r2,r0,r1 yields `ex_val2`=0.
2. **Bypass and R0:**
   - WB writes r1=1546 in the same cycle ADD r2,r0,r1 is in ID -> `ex_val1`=0, `ex_val2`=1546, `ex_dest`=2, `ex_exe_cmd`=0000.
   - WB write of 5 to r0, then read of r0 -> 0.
3. **Immediate sign extension:** ADDI r10,r0,0x8000 -> `ex_val2`=0xFFFF8000, `ex_dest`=10, `ex_wb_en`=1.
4. **BNE:** BNE r1,r3,-15 at pc 296, r1=3, r3=2.
   - Taken: `branch_taken`=1, `branch_address`=240. The next IF/ID holds NOP, and `ex_wb_en`=0 for both the branch and the flushed slot.
   - With r3=3: not taken, and the next instruction is decoded normally.
5. **JMP self-loop:** JMP -1 at pc 376 -> `branch_address`=376; `branch_taken` toggles 1,0,1,0.
6. **ST and BEZ:**
   - ST r2,r1,20 with r1=1024, r2=1546 -> `ex_val1`=1024, `ex_val2`=20, `ex_st_val`=1546, `ex_mem_write`=1, `ex_wb_en`=0.
   - BEZ r5,1 with r5=1546 -> not taken.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, 32x32 register file with write-through
// bypass, decoder, branch resolution feeding fetch, and the ID/EX register.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_pc,
    input  logic        wb_wb_en,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_value,
    output logic        branch_taken,
    output logic [31:0] branch_address,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_val1,
    output logic [31:0] ex_val2,
    output logic [31:0] ex_st_val,
    output logic [4:0]  ex_dest,
    output logic [3:0]  ex_exe_cmd,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_wb_en
);

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    // IF/ID register
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q;

    // Register file
    logic [31:0] regs_q [32];

    // ID/EX register
    logic [31:0] ex_pc_q, ex_pc_d;
    logic [31:0] ex_val1_q, ex_val1_d;
    logic [31:0] ex_val2_q, ex_val2_d;
    logic [31:0] ex_st_val_q, ex_st_val_d;
    logic [4:0]  ex_dest_q, ex_dest_d;
    logic [3:0]  ex_exe_cmd_q, ex_exe_cmd_d;
    logic        ex_mem_read_q, ex_mem_read_d;
    logic        ex_mem_write_q, ex_mem_write_d;
    logic        ex_wb_en_q, ex_wb_en_d;

    // Decoded fields
    logic [5:0]  op;
    logic [4:0]  rs1, rs2, rd_r;
    logic [31:0] imm_ext;
    logic [31:0] rs1_val, rs2_val;
    logic        is_rtype, is_itype, is_load, is_store, branch_cond;
    logic [3:0]  cmd;

    assign op      = instr_q[31:26];
    assign rs1     = instr_q[25:21];
    assign rs2     = instr_q[20:16];
    assign rd_r    = instr_q[15:11];
    assign imm_ext = {{16{instr_q[15]}}, instr_q[15:0]};

    // Reads see a same-cycle write-back so software needs one fewer NOP.
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                     (wb_wb_en && wb_dest == rs1) ? wb_value : regs_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                     (wb_wb_en && wb_dest == rs2) ? wb_value : regs_q[rs2];

    // NOTE: every signal assigned in always_comb gets a default first, otherwise
    // paths that skip an assignment infer a latch.
    always_comb begin
        is_rtype    = 1'b0;
        is_itype    = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        branch_cond = 1'b0;
        cmd         = 4'b0000;
        case (op)
            OP_ADD:  is_rtype = 1'b1;
            OP_SUB:  begin is_rtype = 1'b1; cmd = 4'b0010; end
            OP_AND:  begin is_rtype = 1'b1; cmd = 4'b0100; end
            OP_OR:   begin is_rtype = 1'b1; cmd = 4'b0101; end
            OP_NOR:  begin is_rtype = 1'b1; cmd = 4'b0110; end
            OP_XOR:  begin is_rtype = 1'b1; cmd = 4'b0111; end
            OP_SLA:  begin is_rtype = 1'b1; cmd = 4'b1000; end
            OP_SLL:  begin is_rtype = 1'b1; cmd = 4'b1000; end
            OP_SRA:  begin is_rtype = 1'b1; cmd = 4'b1001; end
            OP_SRL:  begin is_rtype = 1'b1; cmd = 4'b1010; end
            OP_ADDI: is_itype = 1'b1;
            OP_SUBI: begin is_itype = 1'b1; cmd = 4'b0010; end
            OP_LD:   is_load = 1'b1;
            OP_ST:   is_store = 1'b1;
            OP_BEZ:  branch_cond = (rs1_val == 32'd0);
            OP_BNE:  branch_cond = (rs1_val != rs2_val);
            OP_JMP:  branch_cond = 1'b1;
            default: ;
        endcase
    end

    assign branch_taken   = rst & branch_cond;
    assign branch_address = pc_q + 32'd4 + {imm_ext[29:0], 2'b00};

    // A taken branch squashes the wrong-path instruction arriving from fetch.
    assign instr_d = branch_taken ? 32'd0 : if_instruction;

    // Branches, NOPs and unknown opcodes leave everything at zero: a bubble.
    always_comb begin
        ex_pc_d        = 32'd0;
        ex_val1_d      = 32'd0;
        ex_val2_d      = 32'd0;
        ex_st_val_d    = 32'd0;
        ex_dest_d      = 5'd0;
        ex_exe_cmd_d   = 4'b0000;
        ex_mem_read_d  = 1'b0;
        ex_mem_write_d = 1'b0;
        ex_wb_en_d     = 1'b0;
        if (is_rtype || is_itype || is_load || is_store) begin
            ex_pc_d      = pc_q + 32'd4;
            ex_val1_d    = rs1_val;
            ex_exe_cmd_d = cmd;
        end
        if (is_rtype) begin
            ex_val2_d  = rs2_val;
            ex_dest_d  = rd_r;
            ex_wb_en_d = 1'b1;
        end
        if (is_itype || is_load) begin
            ex_val2_d  = imm_ext;
            ex_dest_d  = rs2;
            ex_wb_en_d = 1'b1;
        end
        if (is_load) ex_mem_read_d = 1'b1;
        if (is_store) begin
            ex_val2_d      = imm_ext;
            ex_st_val_d    = rs2_val;
            ex_mem_write_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= if_pc;
        end
    end

    // NOTE: the register file is deliberately reset; this costs a reset net on
    // every entry, so memories elsewhere normally skip it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else if (wb_wb_en && wb_dest != 5'd0) begin
            regs_q[wb_dest] <= wb_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_pc_q        <= 32'd0;
            ex_val1_q      <= 32'd0;
            ex_val2_q      <= 32'd0;
            ex_st_val_q    <= 32'd0;
            ex_dest_q      <= 5'd0;
            ex_exe_cmd_q   <= 4'b0000;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_wb_en_q     <= 1'b0;
        end else begin
            ex_pc_q        <= ex_pc_d;
            ex_val1_q      <= ex_val1_d;
            ex_val2_q      <= ex_val2_d;
            ex_st_val_q    <= ex_st_val_d;
            ex_dest_q      <= ex_dest_d;
            ex_exe_cmd_q   <= ex_exe_cmd_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            ex_wb_en_q     <= ex_wb_en_d;
        end
    end

    assign ex_pc        = ex_pc_q;
    assign ex_val1      = ex_val1_q;
    assign ex_val2      = ex_val2_q;
    assign ex_st_val    = ex_st_val_q;
    assign ex_dest      = ex_dest_q;
    assign ex_exe_cmd   = ex_exe_cmd_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_mem_write = ex_mem_write_q;
    assign ex_wb_en     = ex_wb_en_q;

endmodule
